ctrl_int: RTL and testbench
===========================

Name: ctrl_int

Overview:
- Four-source interrupt controller placed between the e_s I/O block and the control unit (uc).
- Latches rising edges on four request lines and holds them as pending.
- Raises a single irq to uc. On uc's acknowledge it selects a winner, saves the return PC and supplies a vector address into memprog.
- Services one interrupt at a time, with no nesting, until uc signals return-from-interrupt.

Parameters:
- PC_W, 10, program-counter / vector width (matches memprog address width).
- VEC_BASE, 10'h3C0, vector address of source 0.
- VEC_STRIDE, 4, address distance between consecutive source vectors.
- ROTATE, 0, 0 = fixed priority (source 0 highest); 1 = round-robin starting after the last granted source.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high; clears all state.
- req  input  4  interrupt request lines from e_s; a rising edge is an event.
- mask_we  input  1  write strobe for the mask register.
- mask_in  input  4  new mask value; bit=1 disables that source.
- inta  input  1  interrupt acknowledge from uc, one cycle at an instruction boundary.
- reti  input  1  return-from-interrupt from uc, one cycle.
- pc_in  input  PC_W  current PC from uc, sampled on grant.
- irq  output  1  interrupt request to uc.
- vec  output  PC_W  vector address of the granted source; held until the next grant.
- pc_ret  output  PC_W  saved return address; held until the next grant.
- pending  output  4  latched pending events, including masked ones.
- in_service  output  4  one-hot source being serviced; 0 when none.
- mask  output  4  current mask register.

Behaviour:
- **Reset (async, active-high):**
  - All outputs are 0; state is IDLE.
  - mask=0000, so all sources are enabled.
  - The registered previous value of req is 0, so a req line that is high when reset releases produces an edge on the first clock.
  - last_grant=3, so round-robin starts at source 0.
  - Reset mid-service abandons the service: pending, in_service and saved values are all cleared.
- **Edge detect:**
  - pending[i] is set at the clock edge where req[i]=1 and req_prev[i]=0.
  - If a set and a clear of the same bit occur in the same cycle, the set wins and the bit stays 1.
  - A held-high req produces only one event.
- **Mask:**
  - mask_we loads mask_in at the clock edge.
  - A masked pending bit stays latched but cannot raise irq or win.
  - Unmasking a latched bit makes it eligible on the following cycle.
- **eligible** = pending & ~mask.
- **State machine:**
  - IDLE: if eligible≠0, go to REQ at the next edge.
  - REQ (irq=1, registered):
    - If eligible becomes 0 (through a mask write), drop irq and return to IDLE.
    - On inta=1:
      - Pick the winner w from eligible using the priority rule.
      - Load vec=VEC_BASE+w*VEC_STRIDE (truncated to PC_W) and pc_ret=pc_in.
      - Clear pending[w], set in_service=1<<w and last_grant=w.
      - Go to SERV; irq reads 0 in the next cycle.
  - SERV: irq=0. On reti=1, clear in_service and go to IDLE. New events keep latching during SERV.
- **Latency:** the edge is latched at clock k, the state is REQ and irq=1 after clock k+1, and vec/pc_ret are valid the cycle after inta is sampled.
- **Ignored inputs:** inta in IDLE or SERV, and reti in IDLE or REQ.
- **Simultaneous inta and mask write in REQ:** the winner is chosen with the old mask.
- **Round-robin (ROTATE=1):** search order is last_grant+1, +2, +3, +4 modulo 4.
- **Fixed priority (ROTATE=0):** lowest index wins; last_grant is tracked but unused.

Test Plan:
- **Single event:** reset 5 ns, then req=0100 pulse, pc_in=10'h055, inta one cycle after irq. Required: irq=1 two clocks after the edge; after inta, vec=10'h3C8, pc_ret=10'h055, in_service=0100, pending=0000, irq=0. Then reti gives in_service=0000.
- **Fixed-priority collision (ROTATE=0):** req=1010 edge together. Required: first grant vec=10'h3C4 (source 1), pending=1000 remains. After reti, irq rises again and the second grant gives vec=10'h3CC.
- **Round-robin (ROTATE=1):** req 1111 edge. Required grants in order 0,1,2,3 with vecs 3C0,3C4,3C8,3CC. Next, with last_grant=0 and a new 0011 edge, the grant is source 1.
- **Masking:** mask=0001 written, then req=0001 edge. Required: pending=0001, irq stays 0 for 10 cycles. Writing mask=0000 raises irq. A mask write of 0001 again while in REQ drops irq and returns to IDLE.
- **Ignored/edge cases:**
  - inta while IDLE leaves no change.
  - reti while REQ leaves no change.
  - req held high across the grant produces no second event.
  - req re-pulsed during SERV gives pending set and service after reti.
- **Async reset mid-service:** assert reset in SERV (not aligned to clk). Required: all outputs go to 0 immediately and the state is IDLE.

Source files
------------

// File: rtl/ctrl_int_if.sv
// ctrl_int_if: signal bundle between the interrupt controller, the e_s
// request lines and the control unit (uc).
//   slave  : controller side (ctrl_int)
//   master : uc / e_s side (drives requests, mask, inta, reti, pc_in)
// Signals:
//   req[3:0]        request lines, rising edge = event
//   mask_we/mask_in mask register write strobe and value (1 = disabled)
//   inta, reti      acknowledge and return-from-interrupt pulses from uc
//   pc_in           current PC, captured on grant
//   irq             interrupt request to uc
//   vec, pc_ret     vector address and saved return PC of the last grant
//   pending         latched events (masked ones included)
//   in_service      one-hot source under service
//   mask            current mask register
interface ctrl_int_if #(
  parameter int PC_W = 10
);
  logic [3:0]      req;
  logic            mask_we;
  logic [3:0]      mask_in;
  logic            inta;
  logic            reti;
  logic [PC_W-1:0] pc_in;
  logic            irq;
  logic [PC_W-1:0] vec;
  logic [PC_W-1:0] pc_ret;
  logic [3:0]      pending;
  logic [3:0]      in_service;
  logic [3:0]      mask;

  modport slave (
    input  req, mask_we, mask_in, inta, reti, pc_in,
    output irq, vec, pc_ret, pending, in_service, mask
  );

  modport master (
    output req, mask_we, mask_in, inta, reti, pc_in,
    input  irq, vec, pc_ret, pending, in_service, mask
  );
endinterface

// File: rtl/ctrl_int.sv
// ctrl_int: four-source interrupt controller between e_s and uc.
// Latches rising edges of req as pending events, raises irq, and on inta
// grants one eligible source (fixed or round-robin priority), saving the
// return PC and producing the source's vector address. One interrupt is
// serviced at a time until reti.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high; clears all state
//   bus    ctrl_int_if.slave (requests, mask, handshake, vector outputs)
//
// state | meaning
// IDLE  | no request outstanding; waits for an eligible pending event
// REQ   | irq asserted; waits for inta (or falls back if nothing eligible)
// SERV  | a source is being serviced; waits for reti
module ctrl_int #(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] VEC_BASE   = 10'h3C0,
  parameter int              VEC_STRIDE = 4,
  parameter bit              ROTATE     = 1'b0
) (
  input logic        clk,
  input logic        reset,
  ctrl_int_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      req_prev_q;
  logic [3:0]      pending_q, pending_d;
  logic [3:0]      mask_q, mask_d;
  logic [3:0]      in_service_q, in_service_d;
  logic [PC_W-1:0] vec_q, vec_d;
  logic [PC_W-1:0] pc_ret_q, pc_ret_d;
  logic [1:0]      last_grant_q, last_grant_d;
  logic            irq_q, irq_d;

  logic [3:0]      rise;
  logic [3:0]      eligible;
  logic [3:0]      pending_clr;
  logic [1:0]      win;
  logic            win_found;
  logic [1:0]      idx;
  logic [31:0]     vec_off;

  assign rise     = bus.req & ~req_prev_q;
  assign eligible = pending_q & ~mask_q;

  // Winner selection. Round-robin walks last_grant+1 .. last_grant+4 using
  // 2-bit wrap-around; fixed priority lets the lowest index win.
  always_comb begin
    win       = 2'd0;
    win_found = 1'b0;
    idx       = 2'd0;
    if (ROTATE) begin
      for (int k = 1; k <= 4; k++) begin
        idx = last_grant_q + 2'(k);
        if (!win_found && eligible[idx]) begin
          win       = idx;
          win_found = 1'b1;
        end
      end
    end else begin
      for (int k = 3; k >= 0; k--) begin
        if (eligible[k]) begin
          win       = 2'(k);
          win_found = 1'b1;
        end
      end
    end
  end

  assign vec_off = 32'(win) * 32'(VEC_STRIDE);

  always_comb begin
    state_d      = state_q;
    pending_clr  = 4'b0000;
    in_service_d = in_service_q;
    vec_d        = vec_q;
    pc_ret_d     = pc_ret_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (eligible != 4'b0000) state_d = REQ;
      end
      REQ: begin
        // eligible uses the registered mask, so a mask write in the same
        // cycle as inta does not affect this grant.
        if (bus.inta && win_found) begin
          vec_d        = VEC_BASE + vec_off[PC_W-1:0];
          pc_ret_d     = bus.pc_in;
          pending_clr  = 4'b0001 << win;
          in_service_d = 4'b0001 << win;
          last_grant_d = win;
          state_d      = SERV;
        end else if (eligible == 4'b0000) begin
          state_d = IDLE;
        end
      end
      SERV: begin
        if (bus.reti) begin
          in_service_d = 4'b0000;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new edge in the same cycle as the grant clear keeps the bit set.
    pending_d = (pending_q & ~pending_clr) | rise;
    mask_d    = bus.mask_we ? bus.mask_in : mask_q;
    irq_d     = (state_d == REQ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      req_prev_q   <= 4'b0000;
      pending_q    <= 4'b0000;
      mask_q       <= 4'b0000;
      in_service_q <= 4'b0000;
      vec_q        <= '0;
      pc_ret_q     <= '0;
      last_grant_q <= 2'd3;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_prev_q   <= bus.req;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      in_service_q <= in_service_d;
      vec_q        <= vec_d;
      pc_ret_q     <= pc_ret_d;
      last_grant_q <= last_grant_d;
      irq_q        <= irq_d;
    end
  end

  assign bus.irq        = irq_q;
  assign bus.vec        = vec_q;
  assign bus.pc_ret     = pc_ret_q;
  assign bus.pending    = pending_q;
  assign bus.in_service = in_service_q;
  assign bus.mask       = mask_q;

endmodule

// File: tb/tb_ctrl_int.sv
module tb_ctrl_int;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  ctrl_int_if #(.PC_W(10)) f_if ();
  ctrl_int_if #(.PC_W(10)) r_if ();

  ctrl_int #(.PC_W(10), .VEC_BASE(10'h3C0), .VEC_STRIDE(4), .ROTATE(1'b0)) u_fp (
    .clk   (clk),
    .reset (reset),
    .bus   (f_if.slave)
  );

  ctrl_int #(.PC_W(10), .VEC_BASE(10'h3C0), .VEC_STRIDE(4), .ROTATE(1'b1)) u_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (r_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic f_idle();
    f_if.req = 4'b0000; f_if.mask_we = 1'b0; f_if.mask_in = 4'b0000;
    f_if.inta = 1'b0; f_if.reti = 1'b0; f_if.pc_in = 10'h000;
  endtask

  task automatic r_idle();
    r_if.req = 4'b0000; r_if.mask_we = 1'b0; r_if.mask_in = 4'b0000;
    r_if.inta = 1'b0; r_if.reti = 1'b0; r_if.pc_in = 10'h000;
  endtask

  task automatic f_inta();
    f_if.inta = 1'b1; tick(); f_if.inta = 1'b0;
  endtask

  task automatic f_reti();
    f_if.reti = 1'b1; tick(); f_if.reti = 1'b0;
  endtask

  task automatic r_inta();
    r_if.inta = 1'b1; tick(); r_if.inta = 1'b0;
  endtask

  task automatic r_reti();
    r_if.reti = 1'b1; tick(); r_if.reti = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    f_idle();
    r_idle();
    reset = 1'b1;
    #12 reset = 1'b0;
    tick();

    // reset state
    chk_val("rst_irq", 32'(f_if.irq), 32'h0);
    chk_val("rst_vec", 32'(f_if.vec), 32'h0);
    chk_val("rst_pending", 32'(f_if.pending), 32'h0);
    chk_val("rst_mask", 32'(f_if.mask), 32'h0);
    chk_val("rst_insvc", 32'(r_if.in_service), 32'h0);

    // single event on source 2
    f_if.req = 4'b0100; f_if.pc_in = 10'h055;
    tick(); f_if.req = 4'b0000;
    chk_val("s_pend", 32'(f_if.pending), 32'h4);
    chk_val("s_irq_k", 32'(f_if.irq), 32'h0);
    tick();
    chk_val("s_irq_k1", 32'(f_if.irq), 32'h1);
    f_inta();
    chk_val("s_vec", 32'(f_if.vec), 32'h3C8);
    chk_val("s_pcret", 32'(f_if.pc_ret), 32'h055);
    chk_val("s_insvc", 32'(f_if.in_service), 32'h4);
    chk_val("s_pend0", 32'(f_if.pending), 32'h0);
    chk_val("s_irq0", 32'(f_if.irq), 32'h0);
    f_reti();
    chk_val("s_reti", 32'(f_if.in_service), 32'h0);

    // fixed-priority collision
    f_if.req = 4'b1010; f_if.pc_in = 10'h100;
    tick(); f_if.req = 4'b0000;
    tick();
    chk_val("c_irq", 32'(f_if.irq), 32'h1);
    f_inta();
    chk_val("c_vec1", 32'(f_if.vec), 32'h3C4);
    chk_val("c_pend1", 32'(f_if.pending), 32'h8);
    chk_val("c_insvc1", 32'(f_if.in_service), 32'h2);
    f_reti();
    tick();
    chk_val("c_irq2", 32'(f_if.irq), 32'h1);
    f_inta();
    chk_val("c_vec2", 32'(f_if.vec), 32'h3CC);
    chk_val("c_insvc2", 32'(f_if.in_service), 32'h8);
    f_reti();

    // inta while IDLE is ignored
    f_inta();
    chk_val("i_inta_insvc", 32'(f_if.in_service), 32'h0);
    chk_val("i_inta_vec", 32'(f_if.vec), 32'h3CC);
    chk_val("i_inta_irq", 32'(f_if.irq), 32'h0);

    // req held high; reti in REQ ignored; no second event across the grant
    f_if.req = 4'b0001; f_if.pc_in = 10'h200;
    tick(); tick();
    chk_val("h_irq", 32'(f_if.irq), 32'h1);
    f_reti();
    chk_val("h_reti_irq", 32'(f_if.irq), 32'h1);
    chk_val("h_reti_insvc", 32'(f_if.in_service), 32'h0);
    f_inta();
    chk_val("h_vec", 32'(f_if.vec), 32'h3C0);
    chk_val("h_pcret", 32'(f_if.pc_ret), 32'h200);
    tick(); tick(); tick();
    chk_val("h_held_pend", 32'(f_if.pending), 32'h0);

    // re-pulse during SERV latches and is serviced after reti
    f_if.req = 4'b0000; tick();
    f_if.req = 4'b0001; tick();
    f_if.req = 4'b0000;
    chk_val("p_pend", 32'(f_if.pending), 32'h1);
    chk_val("p_irq_serv", 32'(f_if.irq), 32'h0);
    f_reti();
    tick();
    chk_val("p_irq", 32'(f_if.irq), 32'h1);
    f_inta();
    chk_val("p_insvc", 32'(f_if.in_service), 32'h1);
    chk_val("p_pend0", 32'(f_if.pending), 32'h0);
    f_reti();

    // masking
    f_if.mask_we = 1'b1; f_if.mask_in = 4'b0001; tick(); f_if.mask_we = 1'b0;
    chk_val("m_mask", 32'(f_if.mask), 32'h1);
    f_if.req = 4'b0001; tick(); f_if.req = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      chk_val("m_irq_masked", 32'(f_if.irq), 32'h0);
      tick();
    end
    chk_val("m_pend", 32'(f_if.pending), 32'h1);
    f_if.mask_we = 1'b1; f_if.mask_in = 4'b0000; tick(); f_if.mask_we = 1'b0;
    tick();
    chk_val("m_unmask_irq", 32'(f_if.irq), 32'h1);
    f_if.mask_we = 1'b1; f_if.mask_in = 4'b0001; tick(); f_if.mask_we = 1'b0;
    tick();
    chk_val("m_remask_irq", 32'(f_if.irq), 32'h0);
    tick();
    chk_val("m_remask_idle", 32'(f_if.irq), 32'h0);
    chk_val("m_remask_pend", 32'(f_if.pending), 32'h1);

    // inta together with a mask write: old mask decides
    f_if.mask_we = 1'b1; f_if.mask_in = 4'b0000; tick(); f_if.mask_we = 1'b0;
    tick();
    chk_val("x_irq", 32'(f_if.irq), 32'h1);
    f_if.pc_in = 10'h123;
    f_if.mask_we = 1'b1; f_if.mask_in = 4'b0001; f_if.inta = 1'b1;
    tick();
    f_if.mask_we = 1'b0; f_if.inta = 1'b0;
    chk_val("x_insvc", 32'(f_if.in_service), 32'h1);
    chk_val("x_pcret", 32'(f_if.pc_ret), 32'h123);
    chk_val("x_mask", 32'(f_if.mask), 32'h1);

    // async reset in SERV, away from the clock edge
    #3 reset = 1'b1;
    #1;
    chk_val("a_insvc", 32'(f_if.in_service), 32'h0);
    chk_val("a_pcret", 32'(f_if.pc_ret), 32'h0);
    chk_val("a_vec", 32'(f_if.vec), 32'h0);
    chk_val("a_mask", 32'(f_if.mask), 32'h0);
    chk_val("a_irq", 32'(f_if.irq), 32'h0);
    #2 reset = 1'b0;
    tick(); tick();
    chk_val("a_idle_irq", 32'(f_if.irq), 32'h0);

    // round-robin instance
    r_if.req = 4'b1111; r_if.pc_in = 10'h0AA;
    tick(); r_if.req = 4'b0000;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk_val("r_irq", 32'(r_if.irq), 32'h1);
      r_inta();
      chk_val("r_vec", 32'(r_if.vec), 32'h3C0 + 32'(4 * i));
      chk_val("r_insvc", 32'(r_if.in_service), 32'(1 << i));
      r_reti();
      tick();
    end
    chk_val("r_pend0", 32'(r_if.pending), 32'h0);
    chk_val("r_irq0", 32'(r_if.irq), 32'h0);
    r_if.req = 4'b0001; tick(); r_if.req = 4'b0000; tick();
    r_inta();
    chk_val("r_g0", 32'(r_if.in_service), 32'h1);
    r_reti();
    r_if.req = 4'b0011; tick(); r_if.req = 4'b0000; tick();
    r_inta();
    chk_val("r_g1_vec", 32'(r_if.vec), 32'h3C4);
    chk_val("r_g1_insvc", 32'(r_if.in_service), 32'h2);
    chk_val("r_g1_pend", 32'(r_if.pending), 32'h1);
    r_reti();
    tick();
    r_inta();
    chk_val("r_g0b", 32'(r_if.in_service), 32'h1);
    r_reti();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
